rd_mem_noc_responder: RTL and testbench
=======================================

Name: rd_mem_noc_responder

Overview:
- Memory-side end of the NoC load protocol.
- Accepts `MSG_TYPE_LOAD_MEM request header flits on noc0, reads the requested bytes from a local memory port one NoC-data-width beat at a time, and returns a response packet to the requester: one header flit followed by the data flits.
- Sits between the DRAM tile's noc0 router port and its memory controller read interface.

Parameters:
SRC_X, 0, this tile's X coord; placed in the response src_x_coord
SRC_Y, 0, this tile's Y coord; placed in the response src_y_coord
FBITS, 0, this tile's fbits; placed in the response src_fbits

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
noc_rd_resp_req_noc0_val  input  1  incoming request flit valid
noc_rd_resp_req_noc0_data  input  `NOC_DATA_WIDTH  incoming request flit
rd_resp_noc_req_noc0_rdy  output  1  request flit accepted
rd_resp_noc_resp_noc0_val  output  1  outgoing response flit valid
rd_resp_noc_resp_noc0_data  output  `NOC_DATA_WIDTH  outgoing response flit (header or data)
noc_rd_resp_resp_noc0_rdy  input  1  NoC accepts response flit
mem_rd_req_val  output  1  memory read request valid
mem_rd_req_addr  output  `MSG_ADDR_WIDTH  byte address of the beat
mem_rd_req_rdy  input  1  memory accepts the request
mem_rd_resp_val  input  1  read data valid
mem_rd_resp_data  input  `NOC_DATA_WIDTH  one beat of read data
mem_rd_resp_rdy  output  1  read data consumed

Behaviour:
- Reset:
  - state=RECV_HDR.
  - All val/rdy outputs 0.
  - Registered header, beat counter and address are cleared.
  - Reset mid-packet abandons the packet. No partial flits are emitted afterwards.
- Handshakes:
  - A transfer occurs on val&rdy.
  - val never depends combinationally on rdy of the same interface.
  - Data is held stable while val is high and rdy is low.
- Flit count:
  - num_flits = ceil(data_size / `NOC_DATA_BYTES), computed one bit wider than data_size, then truncated to `MSG_LENGTH_WIDTH.
  - data_size=0 gives num_flits=0 (header-only response).
- States:
  - RECV_HDR:
    - req_rdy=1. On a transfer, register the flit.
    - If msg_type==`MSG_TYPE_LOAD_MEM and msg_len==0, go to SEND_HDR.
    - Otherwise go to DRAIN (if msg_len!=0) or stay in RECV_HDR (if msg_len==0), dropping the packet.
  - DRAIN:
    - req_rdy=1. Count accepted flits.
    - After msg_len flits, go to RECV_HDR.
    - Nothing is emitted on the response port.
  - SEND_HDR:
    - resp_val=1. The header data is built from the registered request header:
      - dst_chip_id=req.src_chip_id, dst_x/y=req.src_x/y, fbits=req.src_fbits
      - msg_len=num_flits, msg_type=`MSG_TYPE_LOAD_MEM_ACK
      - addr=req.addr, data_size=req.data_size
      - src_chip_id=0, src_x/y=SRC_X/SRC_Y, src_fbits=FBITS
      - all other fields 0
    - On a transfer: clear beat_cnt, set cur_addr=req.addr, then go to RD_REQ if num_flits!=0, else to RECV_HDR.
  - RD_REQ:
    - mem_rd_req_val=1, mem_rd_req_addr=cur_addr.
    - On a transfer, go to RD_RESP.
  - RD_RESP:
    - Pass-through: resp_val=mem_rd_resp_val, mem_rd_resp_rdy=noc_rd_resp_resp_noc0_rdy, resp_data=mem_rd_resp_data.
    - On a transfer: beat_cnt+=1, cur_addr+=`NOC_DATA_BYTES.
    - If beat_cnt==num_flits-1, go to RECV_HDR; else go to RD_REQ.
- Ordering and overlap:
  - One memory read is outstanding at most.
  - No new request header is accepted until the final data flit transfers. req_rdy=0 in SEND_HDR, RD_REQ and RD_RESP.
- Address arithmetic:
  - Wraps modulo 2^`MSG_ADDR_WIDTH.
  - Alignment is not checked; requesters split requests.
  - The last beat is returned full-width. Padding is the requester's concern.
- Minimum latency:
  - Request accepted at cycle N → response header valid at N+1.
  - First memory request valid one cycle after the header transfer.
  - Data flit valid in the same cycle as mem_rd_resp_val.
- Default state (X/unreachable): drive all next-state values and outputs to X.
- Simulation assertion: mem_rd_resp_val must not be high outside RD_RESP.

Decomposition:
- noc_struct_pkg: noc_hdr_flit (existing).
- noc_defs.vh: add `MSG_TYPE_LOAD_MEM_ACK if absent. Local states_e enum stays inside the module.
- Sub-module: rd_resp_hdr_builder, a combinational function from the registered request header plus parameters to the response noc_hdr_flit and num_flits. It is reusable by the future write responder.
- Everything else lives in one module.

Test Plan:
- Request: addr=0x1000, data_size=128, src=(2,3), src_fbits=4'hA; NOC_DATA_BYTES=64; all rdy=1.
  → Response header: dst=(2,3), fbits=4'hA, msg_len=2, type=LOAD_MEM_ACK.
  → Memory reads at 0x1000 then 0x1040; two data flits equal to the memory data, in order.
  → Then req_rdy=1.
- data_size=0 → header with msg_len=0 only; no mem_rd_req_val; back to RECV_HDR on the cycle after the header transfer.
- data_size=65 → msg_len=2; two beats at addr and addr+64.
- NoC rdy held low 5 cycles during SEND_HDR and during the 2nd data flit:
  - resp_val and resp_data are held stable;
  - mem_rd_resp_rdy=0 throughout;
  - no flit is lost or duplicated.
- Non-LOAD_MEM header with msg_len=3, followed by 3 body flits, then a valid 64-byte load:
  - the first 4 flits are consumed with no response;
  - the load is answered normally with msg_len=1.
- rst asserted while in RD_RESP after 1 of 4 beats → next cycle all val/rdy=0 except req_rdy=1 one cycle after rst drops; no further data flits emitted.

Source files
------------

// File: rtl/rd_mem_noc_responder_pkg.sv
// Shared widths, message types and header flit layout for the
// memory-side NoC load responder.
package rd_mem_noc_responder_pkg;

    localparam int NOC_DATA_WIDTH      = 512;
    localparam int NOC_DATA_BYTES      = NOC_DATA_WIDTH / 8;
    localparam int NOC_DATA_BYTES_LOG2 = $clog2(NOC_DATA_BYTES);

    localparam int MSG_ADDR_WIDTH   = 40;
    localparam int MSG_LENGTH_WIDTH = 8;
    localparam int MSG_TYPE_WIDTH   = 8;
    localparam int DATA_SIZE_WIDTH  = 16;
    localparam int CHIP_ID_WIDTH    = 14;
    localparam int XY_WIDTH         = 8;
    localparam int FBITS_WIDTH      = 4;
    localparam int MSHR_WIDTH       = 8;

    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM     = 8'd19;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK = 8'd24;

    localparam int HDR_USED_WIDTH = 2 * (CHIP_ID_WIDTH + 2 * XY_WIDTH + FBITS_WIDTH)
                                  + MSG_LENGTH_WIDTH + MSG_TYPE_WIDTH + MSHR_WIDTH
                                  + MSG_ADDR_WIDTH + DATA_SIZE_WIDTH;
    localparam int HDR_RSVD_WIDTH = NOC_DATA_WIDTH - HDR_USED_WIDTH;

    typedef struct packed {
        logic [HDR_RSVD_WIDTH-1:0]   rsvd;
        logic [CHIP_ID_WIDTH-1:0]    dst_chip_id;
        logic [XY_WIDTH-1:0]         dst_x;
        logic [XY_WIDTH-1:0]         dst_y;
        logic [FBITS_WIDTH-1:0]      fbits;
        logic [MSG_LENGTH_WIDTH-1:0] msg_len;
        logic [MSG_TYPE_WIDTH-1:0]   msg_type;
        logic [MSHR_WIDTH-1:0]       mshr;
        logic [MSG_ADDR_WIDTH-1:0]   addr;
        logic [DATA_SIZE_WIDTH-1:0]  data_size;
        logic [CHIP_ID_WIDTH-1:0]    src_chip_id;
        logic [XY_WIDTH-1:0]         src_x;
        logic [XY_WIDTH-1:0]         src_y;
        logic [FBITS_WIDTH-1:0]      src_fbits;
    } noc_hdr_flit;

    // The extra bit keeps the round-up from overflowing before truncation.
    function automatic logic [MSG_LENGTH_WIDTH-1:0] calc_num_flits(
        input logic [DATA_SIZE_WIDTH-1:0] size
    );
        logic [DATA_SIZE_WIDTH:0] sum;
        sum = {1'b0, size} + (DATA_SIZE_WIDTH + 1)'(NOC_DATA_BYTES - 1);
        return MSG_LENGTH_WIDTH'(sum >> NOC_DATA_BYTES_LOG2);
    endfunction

endpackage

// File: rtl/rd_mem_noc_responder_if.sv
// NoC request/response and memory read handshakes of the load responder.
interface rd_mem_noc_responder_if;
    import rd_mem_noc_responder_pkg::*;

    logic                      noc_rd_resp_req_noc0_val;
    logic [NOC_DATA_WIDTH-1:0] noc_rd_resp_req_noc0_data;
    logic                      rd_resp_noc_req_noc0_rdy;

    logic                      rd_resp_noc_resp_noc0_val;
    logic [NOC_DATA_WIDTH-1:0] rd_resp_noc_resp_noc0_data;
    logic                      noc_rd_resp_resp_noc0_rdy;

    logic                      mem_rd_req_val;
    logic [MSG_ADDR_WIDTH-1:0] mem_rd_req_addr;
    logic                      mem_rd_req_rdy;

    logic                      mem_rd_resp_val;
    logic [NOC_DATA_WIDTH-1:0] mem_rd_resp_data;
    logic                      mem_rd_resp_rdy;

    modport slave (
        input  noc_rd_resp_req_noc0_val,
        input  noc_rd_resp_req_noc0_data,
        output rd_resp_noc_req_noc0_rdy,
        output rd_resp_noc_resp_noc0_val,
        output rd_resp_noc_resp_noc0_data,
        input  noc_rd_resp_resp_noc0_rdy,
        output mem_rd_req_val,
        output mem_rd_req_addr,
        input  mem_rd_req_rdy,
        input  mem_rd_resp_val,
        input  mem_rd_resp_data,
        output mem_rd_resp_rdy
    );

    modport master (
        output noc_rd_resp_req_noc0_val,
        output noc_rd_resp_req_noc0_data,
        input  rd_resp_noc_req_noc0_rdy,
        input  rd_resp_noc_resp_noc0_val,
        input  rd_resp_noc_resp_noc0_data,
        output noc_rd_resp_resp_noc0_rdy,
        input  mem_rd_req_val,
        input  mem_rd_req_addr,
        output mem_rd_req_rdy,
        output mem_rd_resp_val,
        output mem_rd_resp_data,
        input  mem_rd_resp_rdy
    );

endinterface

// File: rtl/rd_resp_hdr_builder.sv
// Builds the response header and flit count from a registered request
// header; shared with the write responder.
module rd_resp_hdr_builder
    import rd_mem_noc_responder_pkg::*;
#(
    parameter int SRC_X = 0,
    parameter int SRC_Y = 0,
    parameter int FBITS = 0
) (
    input  noc_hdr_flit                  req,
    output noc_hdr_flit                  resp,
    output logic [MSG_LENGTH_WIDTH-1:0]  num_flits
);

    logic [MSG_LENGTH_WIDTH-1:0] nf;
    logic                        unused_req;

    assign nf         = calc_num_flits(req.data_size);
    assign num_flits  = nf;
    assign unused_req = ^{req.rsvd, req.dst_chip_id, req.dst_x, req.dst_y,
                          req.fbits, req.msg_len, req.msg_type, req.mshr};

    always_comb begin
        resp             = '0;
        resp.dst_chip_id = req.src_chip_id;
        resp.dst_x       = req.src_x;
        resp.dst_y       = req.src_y;
        resp.fbits       = req.src_fbits;
        resp.msg_len     = nf;
        resp.msg_type    = MSG_TYPE_LOAD_MEM_ACK;
        resp.addr        = req.addr;
        resp.data_size   = req.data_size;
        resp.src_chip_id = '0;
        resp.src_x       = XY_WIDTH'(SRC_X);
        resp.src_y       = XY_WIDTH'(SRC_Y);
        resp.src_fbits   = FBITS_WIDTH'(FBITS);
    end

endmodule

// File: rtl/rd_mem_noc_responder.sv
// Memory-side end of the NoC load protocol: one header flit followed by
// one data flit per memory beat, with a single read outstanding.
module rd_mem_noc_responder
    import rd_mem_noc_responder_pkg::*;
#(
    parameter int SRC_X = 0,
    parameter int SRC_Y = 0,
    parameter int FBITS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    rd_mem_noc_responder_if.slave bus
);

    typedef enum logic [2:0] {
        RECV_HDR,
        DRAIN,
        SEND_HDR,
        RD_REQ,
        RD_RESP
    } states_e;

    localparam logic [MSG_LENGTH_WIDTH-1:0] LEN_ONE    = MSG_LENGTH_WIDTH'(1);
    localparam logic [MSG_ADDR_WIDTH-1:0]   BEAT_BYTES = MSG_ADDR_WIDTH'(NOC_DATA_BYTES);

    states_e                     state;
    logic                        live;
    noc_hdr_flit                 in_hdr;
    noc_hdr_flit                 req_hdr;
    noc_hdr_flit                 resp_hdr;
    logic [MSG_LENGTH_WIDTH-1:0] num_flits;
    logic [MSG_LENGTH_WIDTH-1:0] beat_cnt;
    logic [MSG_ADDR_WIDTH-1:0]   cur_addr;

    logic                        req_rdy;
    logic                        resp_val;
    logic [NOC_DATA_WIDTH-1:0]   resp_data;
    logic                        mreq_val;
    logic                        mresp_rdy;
    logic                        req_xfer;
    logic                        resp_xfer;
    logic                        mreq_xfer;

    rd_resp_hdr_builder #(
        .SRC_X (SRC_X),
        .SRC_Y (SRC_Y),
        .FBITS (FBITS)
    ) u_hdr_builder (
        .req       (req_hdr),
        .resp      (resp_hdr),
        .num_flits (num_flits)
    );

    assign in_hdr    = bus.noc_rd_resp_req_noc0_data;
    assign req_xfer  = bus.noc_rd_resp_req_noc0_val & req_rdy;
    assign resp_xfer = resp_val & bus.noc_rd_resp_resp_noc0_rdy;
    assign mreq_xfer = mreq_val & bus.mem_rd_req_rdy;

    // live holds every handshake low until the first cycle after reset.
    always_comb begin
        req_rdy   = 1'b0;
        resp_val  = 1'b0;
        resp_data = '0;
        mreq_val  = 1'b0;
        mresp_rdy = 1'b0;
        unique case (state)
            RECV_HDR: req_rdy = live;
            DRAIN:    req_rdy = 1'b1;
            SEND_HDR: begin
                resp_val  = 1'b1;
                resp_data = resp_hdr;
            end
            RD_REQ:   mreq_val = 1'b1;
            RD_RESP: begin
                resp_val  = bus.mem_rd_resp_val;
                resp_data = bus.mem_rd_resp_data;
                mresp_rdy = bus.noc_rd_resp_resp_noc0_rdy;
            end
            default: begin
                req_rdy   = 1'bx;
                resp_val  = 1'bx;
                resp_data = 'x;
                mreq_val  = 1'bx;
                mresp_rdy = 1'bx;
            end
        endcase
    end

    assign bus.rd_resp_noc_req_noc0_rdy   = req_rdy;
    assign bus.rd_resp_noc_resp_noc0_val  = resp_val;
    assign bus.rd_resp_noc_resp_noc0_data = resp_data;
    assign bus.mem_rd_req_val             = mreq_val;
    assign bus.mem_rd_req_addr            = cur_addr;
    assign bus.mem_rd_resp_rdy            = mresp_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RECV_HDR;
            live     <= 1'b0;
            req_hdr  <= '0;
            beat_cnt <= '0;
            cur_addr <= '0;
        end else begin
            live <= 1'b1;
            unique case (state)
                RECV_HDR: begin
                    if (req_xfer) begin
                        req_hdr  <= in_hdr;
                        beat_cnt <= '0;
                        if (in_hdr.msg_type == MSG_TYPE_LOAD_MEM && in_hdr.msg_len == '0)
                            state <= SEND_HDR;
                        else if (in_hdr.msg_len != '0)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (req_xfer) begin
                        beat_cnt <= beat_cnt + LEN_ONE;
                        if (beat_cnt == req_hdr.msg_len - LEN_ONE)
                            state <= RECV_HDR;
                    end
                end
                SEND_HDR: begin
                    if (resp_xfer) begin
                        beat_cnt <= '0;
                        cur_addr <= req_hdr.addr;
                        state    <= (num_flits != '0) ? RD_REQ : RECV_HDR;
                    end
                end
                RD_REQ: begin
                    if (mreq_xfer)
                        state <= RD_RESP;
                end
                RD_RESP: begin
                    if (resp_xfer) begin
                        beat_cnt <= beat_cnt + LEN_ONE;
                        cur_addr <= cur_addr + BEAT_BYTES;
                        state    <= (beat_cnt == num_flits - LEN_ONE) ? RECV_HDR : RD_REQ;
                    end
                end
                default: begin
                    state    <= states_e'(3'bxxx);
                    req_hdr  <= 'x;
                    beat_cnt <= 'x;
                    cur_addr <= 'x;
                end
            endcase
        end
    end

    a_mem_resp_in_rd_resp: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.mem_rd_resp_val && state != RD_RESP)
    );

endmodule

// File: tb/tb_rd_mem_noc_responder.sv
// Directed bench for rd_mem_noc_responder: table of loads plus drain,
// back-pressure and mid-packet reset sequences.
module tb_rd_mem_noc_responder;
    import rd_mem_noc_responder_pkg::*;

    localparam int TB_SRC_X = 5;
    localparam int TB_SRC_Y = 6;
    localparam int TB_FBITS = 2;

    typedef struct {
        logic [MSG_ADDR_WIDTH-1:0] addr;
        logic [15:0]               size;
        logic [13:0]               chip;
        logic [7:0]                sx;
        logic [7:0]                sy;
        logic [3:0]                fb;
        bit                        stall_hdr;
        int                        stall_beat;
        int                        exp_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[6];
    vec_t v;

    rd_mem_noc_responder_if bus ();

    rd_mem_noc_responder #(
        .SRC_X (TB_SRC_X),
        .SRC_Y (TB_SRC_Y),
        .FBITS (TB_FBITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NOC_DATA_WIDTH-1:0] act,
                       input logic [NOC_DATA_WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [NOC_DATA_WIDTH-1:0] pat(input logic [MSG_ADDR_WIDTH-1:0] a);
        return {8{24'hC0FFEE, a}};
    endfunction

    function automatic noc_hdr_flit req_flit(input logic [7:0] mtype, input logic [7:0] mlen,
                                             input vec_t rv);
        noc_hdr_flit h;
        h             = '0;
        h.rsvd        = '1;
        h.mshr        = 8'h5A;
        h.dst_x       = 8'(TB_SRC_X);
        h.dst_y       = 8'(TB_SRC_Y);
        h.fbits       = 4'(TB_FBITS);
        h.msg_type    = mtype;
        h.msg_len     = mlen;
        h.addr        = rv.addr;
        h.data_size   = rv.size;
        h.src_chip_id = rv.chip;
        h.src_x       = rv.sx;
        h.src_y       = rv.sy;
        h.src_fbits   = rv.fb;
        return h;
    endfunction

    function automatic noc_hdr_flit exp_hdr(input vec_t rv);
        noc_hdr_flit h;
        h             = '0;
        h.dst_chip_id = rv.chip;
        h.dst_x       = rv.sx;
        h.dst_y       = rv.sy;
        h.fbits       = rv.fb;
        h.msg_len     = 8'(rv.exp_len);
        h.msg_type    = MSG_TYPE_LOAD_MEM_ACK;
        h.addr        = rv.addr;
        h.data_size   = rv.size;
        h.src_x       = 8'(TB_SRC_X);
        h.src_y       = 8'(TB_SRC_Y);
        h.src_fbits   = 4'(TB_FBITS);
        return h;
    endfunction

    task automatic do_load(input vec_t rv, input string tg);
        noc_hdr_flit               eh;
        logic [MSG_ADDR_WIDTH-1:0] a;
        bit                        st;
        eh = exp_hdr(rv);
        @(negedge clk);
        bus.noc_rd_resp_req_noc0_val  = 1'b1;
        bus.noc_rd_resp_req_noc0_data = req_flit(MSG_TYPE_LOAD_MEM, 8'd0, rv);
        #1 chk({tg, ".req_rdy"}, bus.rd_resp_noc_req_noc0_rdy, 1);
        @(negedge clk);
        bus.noc_rd_resp_req_noc0_val  = 1'b0;
        bus.noc_rd_resp_req_noc0_data = '0;
        bus.noc_rd_resp_resp_noc0_rdy = !rv.stall_hdr;
        #1;
        chk({tg, ".hdr_val"}, bus.rd_resp_noc_resp_noc0_val, 1);
        chk({tg, ".hdr"}, bus.rd_resp_noc_resp_noc0_data, eh);
        chk({tg, ".busy_rdy"}, bus.rd_resp_noc_req_noc0_rdy, 0);
        if (rv.stall_hdr) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                bus.noc_rd_resp_resp_noc0_rdy = (k == 4);
                #1;
                chk({tg, ".hdr_hold_val"}, bus.rd_resp_noc_resp_noc0_val, 1);
                chk({tg, ".hdr_hold"}, bus.rd_resp_noc_resp_noc0_data, eh);
                chk({tg, ".hdr_hold_mreq"}, bus.mem_rd_req_val, 0);
            end
        end
        a = rv.addr;
        for (int i = 0; i < rv.exp_len; i++) begin
            @(negedge clk);
            bus.mem_rd_resp_val  = 1'b0;
            bus.mem_rd_resp_data = '0;
            #1;
            chk({tg, ".mreq_val"}, bus.mem_rd_req_val, 1);
            chk({tg, ".mreq_addr"}, bus.mem_rd_req_addr, a);
            chk({tg, ".no_stray"}, bus.rd_resp_noc_resp_noc0_val, 0);
            st = (i == rv.stall_beat);
            @(negedge clk);
            bus.mem_rd_resp_val           = 1'b1;
            bus.mem_rd_resp_data          = pat(a);
            bus.noc_rd_resp_resp_noc0_rdy = !st;
            #1;
            chk({tg, ".beat_val"}, bus.rd_resp_noc_resp_noc0_val, 1);
            chk({tg, ".beat_data"}, bus.rd_resp_noc_resp_noc0_data, pat(a));
            chk({tg, ".mrsp_rdy"}, bus.mem_rd_resp_rdy, !st);
            if (st) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    bus.noc_rd_resp_resp_noc0_rdy = (k == 4);
                    #1;
                    chk({tg, ".beat_hold_val"}, bus.rd_resp_noc_resp_noc0_val, 1);
                    chk({tg, ".beat_hold"}, bus.rd_resp_noc_resp_noc0_data, pat(a));
                    chk({tg, ".hold_mrsp_rdy"}, bus.mem_rd_resp_rdy, (k == 4));
                end
            end
            a = a + MSG_ADDR_WIDTH'(NOC_DATA_BYTES);
        end
        @(negedge clk);
        bus.mem_rd_resp_val           = 1'b0;
        bus.mem_rd_resp_data          = '0;
        bus.noc_rd_resp_resp_noc0_rdy = 1'b1;
        #1;
        chk({tg, ".end_req_rdy"}, bus.rd_resp_noc_req_noc0_rdy, 1);
        chk({tg, ".end_resp_val"}, bus.rd_resp_noc_resp_noc0_val, 0);
        chk({tg, ".end_mreq_val"}, bus.mem_rd_req_val, 0);
    endtask

    task automatic chk_idle(input string tg, input logic exp_req_rdy);
        chk({tg, ".req_rdy"}, bus.rd_resp_noc_req_noc0_rdy, exp_req_rdy);
        chk({tg, ".resp_val"}, bus.rd_resp_noc_resp_noc0_val, 0);
        chk({tg, ".mreq_val"}, bus.mem_rd_req_val, 0);
        chk({tg, ".mrsp_rdy"}, bus.mem_rd_resp_rdy, 0);
    endtask

    initial begin
        vecs[0] = '{40'h00_0000_1000, 16'd128, 14'd0,  8'd2, 8'd3, 4'hA, 1'b0, -1, 2};
        vecs[1] = '{40'h00_0000_2000, 16'd0,   14'd1,  8'd7, 8'd1, 4'h3, 1'b0, -1, 0};
        vecs[2] = '{40'h00_0000_3000, 16'd65,  14'd2,  8'd4, 8'd9, 4'h5, 1'b0, -1, 2};
        vecs[3] = '{40'h00_0000_4000, 16'd128, 14'd3,  8'd1, 8'd2, 4'hC, 1'b1, 1,  2};
        vecs[4] = '{40'hFF_FFFF_FFC0, 16'd100, 14'd9,  8'd3, 8'd3, 4'h1, 1'b0, -1, 2};
        vecs[5] = '{40'h00_0000_5004, 16'd1,   14'd12, 8'd0, 8'd8, 4'hF, 1'b0, 0,  1};

        bus.noc_rd_resp_req_noc0_val  = 1'b0;
        bus.noc_rd_resp_req_noc0_data = '0;
        bus.noc_rd_resp_resp_noc0_rdy = 1'b1;
        bus.mem_rd_req_rdy            = 1'b1;
        bus.mem_rd_resp_val           = 1'b0;
        bus.mem_rd_resp_data          = '0;

        repeat (3) @(negedge clk);
        #1 chk_idle("rst", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_idle("rst_drop", 1'b0);
        @(negedge clk);
        #1 chk_idle("rst_after", 1'b1);

        for (int i = 0; i < 6; i++)
            do_load(vecs[i], $sformatf("vec%0d", i));

        // Foreign header with three body flits; one body flit mimics a load.
        v = '{40'h00_0000_6000, 16'd64, 14'd4, 8'd6, 8'd2, 4'h7, 1'b0, -1, 1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.noc_rd_resp_req_noc0_val = 1'b1;
            if (i == 0)
                bus.noc_rd_resp_req_noc0_data = req_flit(8'd1, 8'd3, v);
            else if (i == 2)
                bus.noc_rd_resp_req_noc0_data = req_flit(MSG_TYPE_LOAD_MEM, 8'd0, v);
            else
                bus.noc_rd_resp_req_noc0_data = {16{32'hDEAD_0000 + 32'(i)}};
            #1 chk_idle($sformatf("drain%0d", i), 1'b1);
        end
        do_load(v, "after_drain");

        // Reset during the second of four beats.
        v = '{40'h00_0000_8000, 16'd256, 14'd5, 8'd1, 8'd1, 4'h2, 1'b0, -1, 4};
        @(negedge clk);
        bus.noc_rd_resp_req_noc0_val  = 1'b1;
        bus.noc_rd_resp_req_noc0_data = req_flit(MSG_TYPE_LOAD_MEM, 8'd0, v);
        @(negedge clk);
        bus.noc_rd_resp_req_noc0_val  = 1'b0;
        bus.noc_rd_resp_req_noc0_data = '0;
        #1 chk("rr.hdr", bus.rd_resp_noc_resp_noc0_data, exp_hdr(v));
        @(negedge clk);
        #1 chk("rr.mreq0", bus.mem_rd_req_addr, 40'h00_0000_8000);
        @(negedge clk);
        bus.mem_rd_resp_val  = 1'b1;
        bus.mem_rd_resp_data = pat(40'h00_0000_8000);
        #1 chk("rr.beat0", bus.rd_resp_noc_resp_noc0_data, pat(40'h00_0000_8000));
        @(negedge clk);
        bus.mem_rd_resp_val = 1'b0;
        #1 chk("rr.mreq1", bus.mem_rd_req_addr, 40'h00_0000_8040);
        @(negedge clk);
        bus.mem_rd_resp_val           = 1'b1;
        bus.mem_rd_resp_data          = pat(40'h00_0000_8040);
        bus.noc_rd_resp_resp_noc0_rdy = 1'b0;
        rst                           = 1'b1;
        @(negedge clk);
        bus.mem_rd_resp_val           = 1'b0;
        bus.mem_rd_resp_data          = '0;
        bus.noc_rd_resp_resp_noc0_rdy = 1'b1;
        #1 chk_idle("rr.in_rst", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_idle("rr.drop", 1'b0);
        @(negedge clk);
        #1 chk_idle("rr.after", 1'b1);
        repeat (4) begin
            @(negedge clk);
            #1 chk_idle("rr.quiet", 1'b1);
        end
        do_load(vecs[2], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
